// File: rtl/multi_lane_pcoeff_aggregator.sv
// Multi-lane connect-count aggregator: decodes each lane count to 2^count and accumulates per batch.
// Define AGG_SATURATE_EN to saturate the batch sum/num (and flag err) instead of wrapping.
module multi_lane_pcoeff_aggregator #(
    parameter int LANES     = 4,
    parameter int CC_W      = 6,
    parameter int MAX_COUNT = 35,
    parameter int NUM_W     = 16,
    parameter int RES_DEPTH = 2,
    localparam int SUM_W    = NUM_W + MAX_COUNT + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*CC_W-1:0] in_count,
    input  logic                  in_last,
    input  logic                  in_ecc,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SUM_W-1:0]      res_sum,
    output logic [NUM_W-1:0]      res_num,
    output logic                  res_err
);

    localparam int POP_W = $clog2(LANES + 1);
`ifdef AGG_SATURATE_EN
    localparam int BSUM_W = SUM_W + POP_W;
`else
    localparam int BSUM_W = SUM_W;
`endif
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1);

    logic              accept;
    logic [BSUM_W-1:0] beat_sum;
    logic [POP_W-1:0]  beat_pop;
    logic              beat_over;

    logic              s1_valid;
    logic [BSUM_W-1:0] s1_sum;
    logic [POP_W-1:0]  s1_pop;
    logic              s1_err;
    logic              s1_last;

    logic [SUM_W-1:0]  acc_sum;
    logic [NUM_W-1:0]  acc_num;
    logic              acc_err;
    logic [SUM_W-1:0]  next_sum;
    logic [NUM_W-1:0]  next_num;
    logic              next_err;

    logic [SUM_W-1:0]  mem_sum [RES_DEPTH];
    logic [NUM_W-1:0]  mem_num [RES_DEPTH];
    logic              mem_err [RES_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;
    logic              last_in_flight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == RES_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // A pending last beat reserves its buffer slot so a result can never find the FIFO full.
    assign last_in_flight = s1_valid && s1_last;
    assign in_ready = !rst && ((int'(fifo_count) + int'(last_in_flight)) < RES_DEPTH);
    assign accept   = in_valid && in_ready;
    assign push     = last_in_flight;
    assign pop      = res_valid && res_ready;

    always_comb begin
        beat_sum  = '0;
        beat_pop  = '0;
        beat_over = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_valid[i]) begin
                beat_pop = beat_pop + POP_W'(1);
                if (int'(in_count[i*CC_W +: CC_W]) > MAX_COUNT)
                    beat_over = 1'b1;
                else
                    beat_sum = beat_sum + (BSUM_W'(1) << in_count[i*CC_W +: CC_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_pop   <= '0;
            s1_err   <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum  <= beat_sum;
                s1_pop  <= beat_pop;
                s1_err  <= beat_over || in_ecc;
                s1_last <= in_last;
            end
        end
    end

`ifdef AGG_SATURATE_EN
    logic [BSUM_W:0]      sum_ext;
    logic [NUM_W+POP_W:0] num_ext;
    logic                 sum_ovf;
    logic                 num_ovf;

    always_comb begin
        sum_ext  = (BSUM_W+1)'(acc_sum) + (BSUM_W+1)'(s1_sum);
        num_ext  = (NUM_W+POP_W+1)'(acc_num) + (NUM_W+POP_W+1)'(s1_pop);
        sum_ovf  = |sum_ext[BSUM_W:SUM_W];
        num_ovf  = |num_ext[NUM_W+POP_W:NUM_W];
        next_sum = sum_ovf ? '1 : sum_ext[SUM_W-1:0];
        next_num = num_ovf ? '1 : num_ext[NUM_W-1:0];
        next_err = acc_err || s1_err || sum_ovf || num_ovf;
    end
`else
    always_comb begin
        next_sum = acc_sum + s1_sum;
        next_num = acc_num + NUM_W'(s1_pop);
        next_err = acc_err || s1_err;
    end
`endif

    // The accumulator clears as the last beat's total goes to the buffer, so the next batch starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum <= '0;
            acc_num <= '0;
            acc_err <= 1'b0;
        end else if (s1_valid) begin
            if (s1_last) begin
                acc_sum <= '0;
                acc_num <= '0;
                acc_err <= 1'b0;
            end else begin
                acc_sum <= next_sum;
                acc_num <= next_num;
                acc_err <= next_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_sum[i] <= '0;
                mem_num[i] <= '0;
                mem_err[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_sum[wr_ptr] <= next_sum;
                mem_num[wr_ptr] <= next_num;
                mem_err[wr_ptr] <= next_err;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Outputs are forced to zero during reset, before the first reset edge has cleared storage.
    assign res_valid = !rst && (fifo_count != '0);
    assign res_sum   = rst ? '0 : mem_sum[rd_ptr];
    assign res_num   = rst ? '0 : mem_num[rd_ptr];
    assign res_err   = rst ? 1'b0 : mem_err[rd_ptr];

endmodule

// File: tb/tb_multi_lane_pcoeff_aggregator.sv
// Directed bench for multi_lane_pcoeff_aggregator: default instance plus a NUM_W=2 instance for wrap/saturate.
module tb_multi_lane_pcoeff_aggregator;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_last, a_in_ecc;
    logic [3:0]  a_in_lane_valid;
    logic [23:0] a_in_count;
    logic        a_res_valid, a_res_ready, a_res_err;
    logic [51:0] a_res_sum;
    logic [15:0] a_res_num;

    logic        b_in_valid, b_in_ready, b_in_last, b_in_ecc;
    logic [3:0]  b_in_lane_valid;
    logic [23:0] b_in_count;
    logic        b_res_valid, b_res_ready, b_res_err;
    logic [37:0] b_res_sum;
    logic [1:0]  b_res_num;

    int tests_run    = 0;
    int tests_failed = 0;

    multi_lane_pcoeff_aggregator dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_lane_valid(a_in_lane_valid), .in_count(a_in_count),
        .in_last(a_in_last), .in_ecc(a_in_ecc),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_sum(a_res_sum), .res_num(a_res_num), .res_err(a_res_err)
    );

    multi_lane_pcoeff_aggregator #(.NUM_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_lane_valid(b_in_lane_valid), .in_count(b_in_count),
        .in_last(b_in_last), .in_ecc(b_in_ecc),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_sum(b_res_sum), .res_num(b_res_num), .res_err(b_res_err)
    );

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one beat on instance A once in_ready is seen, then leaves junk on the idle bus.
    task automatic apply_stimulus(input logic [3:0] mask, input logic [23:0] counts,
                                  input logic last, input logic ecc);
        int n = 0;
        while (!a_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_value("in_ready_wait", 64'(a_in_ready), 64'd1);
        a_in_valid      = 1'b1;
        a_in_lane_valid = mask;
        a_in_count      = counts;
        a_in_last       = last;
        a_in_ecc        = ecc;
        @(posedge clk); #1;
        a_in_valid      = 1'b0;
        a_in_lane_valid = 4'hF;
        a_in_count      = '1;
        a_in_last       = 1'b1;
        a_in_ecc        = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] sum,
                                input logic [63:0] num, input logic err);
        int n = 0;
        while (!a_res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_value({tag, "_valid"}, 64'(a_res_valid), 64'd1);
        check_value({tag, "_sum"}, 64'(a_res_sum), sum);
        check_value({tag, "_num"}, 64'(a_res_num), num);
        check_value({tag, "_err"}, 64'(a_res_err), 64'(err));
        a_res_ready = 1'b1;
        @(posedge clk); #1;
        a_res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_lane_valid = '0; a_in_count = '0; a_in_last = 1'b0; a_in_ecc = 1'b0;
        a_res_ready = 1'b0;
        b_in_valid = 1'b0; b_in_lane_valid = '0; b_in_count = '0; b_in_last = 1'b0; b_in_ecc = 1'b0;
        b_res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_in_ready", 64'(a_in_ready), 64'd0);
        check_value("rst_res_valid", 64'(a_res_valid), 64'd0);
        check_value("rst_res_sum", 64'(a_res_sum), 64'd0);
        check_value("rst_res_num", 64'(a_res_num), 64'd0);
        check_value("rst_res_err", 64'(a_res_err), 64'd0);
        rst = 1'b0;
        #1;
        check_value("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Single full beat: 2^0 + 2^1 + 2^2 + 2^35, exactly two cycles of latency.
        apply_stimulus(4'hF, {6'd35, 6'd2, 6'd1, 6'd0}, 1'b1, 1'b0);
        check_value("latency_early", 64'(a_res_valid), 64'd0);
        @(posedge clk); #1;
        check_value("latency_two", 64'(a_res_valid), 64'd1);
        check_output("single", 64'd34359738375, 64'd4, 1'b0);

        // Three beats of two lanes at count 5, then a one-beat batch right behind.
        apply_stimulus(4'h3, {12'd0, 6'd5, 6'd5}, 1'b0, 1'b0);
        apply_stimulus(4'h3, {12'd0, 6'd5, 6'd5}, 1'b0, 1'b0);
        apply_stimulus(4'h3, {12'd0, 6'd5, 6'd5}, 1'b1, 1'b0);
        apply_stimulus(4'h1, {18'd0, 6'd3}, 1'b1, 1'b0);
        check_output("multi", 64'd192, 64'd6, 1'b0);
        check_output("follow", 64'd8, 64'd1, 1'b0);

        // Over-range lane, a clean batch after it, and an empty last beat carrying ecc.
        apply_stimulus(4'h3, {12'd0, 6'd4, 6'd36}, 1'b1, 1'b0);
        check_output("overrange", 64'd16, 64'd2, 1'b1);
        apply_stimulus(4'h1, {18'd0, 6'd0}, 1'b1, 1'b0);
        check_output("after_err", 64'd1, 64'd1, 1'b0);
        apply_stimulus(4'h0, 24'd0, 1'b1, 1'b1);
        check_output("empty_ecc", 64'd0, 64'd0, 1'b1);

        // Backpressure: two results fill the buffer, a third batch waits on in_ready.
        apply_stimulus(4'h1, {18'd0, 6'd7}, 1'b1, 1'b0);
        apply_stimulus(4'h1, {18'd0, 6'd8}, 1'b1, 1'b0);
        check_value("bp_ready_low", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b1; a_in_lane_valid = 4'h1; a_in_count = {18'd0, 6'd9};
        a_in_last = 1'b1; a_in_ecc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("bp_hold_ready", 64'(a_in_ready), 64'd0);
        check_value("bp_head_stable", 64'(a_res_sum), 64'd128);
        a_res_ready = 1'b1;
        @(posedge clk); #1;
        a_res_ready = 1'b0;
        check_value("bp_release", 64'(a_in_ready), 64'd1);
        check_value("bp_next_head", 64'(a_res_sum), 64'd256);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check_output("order2", 64'd256, 64'd1, 1'b0);
        check_output("order3", 64'd512, 64'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_value("no_duplicate", 64'(a_res_valid), 64'd0);

        // Reset while a partial batch and its last beat are in flight.
        apply_stimulus(4'h1, {18'd0, 6'd4}, 1'b0, 1'b0);
        apply_stimulus(4'h1, {18'd0, 6'd5}, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_value("mid_rst_valid", 64'(a_res_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_value("rst_drop", 64'(a_res_valid), 64'd0);
        apply_stimulus(4'h1, {18'd0, 6'd1}, 1'b1, 1'b0);
        check_output("post_rst", 64'd2, 64'd1, 1'b0);

        // Five counts of 0 into a 2-bit num.
        check_value("b_in_ready", 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b1; b_in_lane_valid = 4'hF; b_in_count = '0; b_in_last = 1'b0;
        @(posedge clk); #1;
        b_in_lane_valid = 4'h1; b_in_last = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        @(posedge clk); #1;
        check_value("b_valid", 64'(b_res_valid), 64'd1);
        check_value("b_sum", 64'(b_res_sum), 64'd5);
`ifdef AGG_SATURATE_EN
        check_value("b_num", 64'(b_res_num), 64'd3);
        check_value("b_err", 64'(b_res_err), 64'd1);
`else
        check_value("b_num", 64'(b_res_num), 64'd1);
        check_value("b_err", 64'(b_res_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_lane_pcoeff_aggregator.md
MULTI_LANE_PCOEFF_AGGREGATOR -- requirements
Module: multi_lane_pcoeff_aggregator

Interface
REQ-001 SHALL have parameter LANES, default 4: connect-count lanes per input beat.
REQ-002 SHALL have parameter CC_W, default 6: width of each connect count.
REQ-003 SHALL have parameter MAX_COUNT, default 35: largest legal connect count.
REQ-004 SHALL have parameter NUM_W, default 16: width of the per-batch result count.
REQ-005 SHALL have parameter RES_DEPTH, default 2: result buffer entries, minimum 1.
REQ-006 SHALL have a derived width SUM_W = NUM_W+MAX_COUNT+1.
REQ-007 SHALL have port clk, input, 1: clock.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1: input beat present.
REQ-010 SHALL have port in_ready, output, 1: beat accepted when in_valid&&in_ready.
REQ-011 SHALL have port in_lane_valid, input, LANES: per-lane count valid mask.
REQ-012 SHALL have port in_count, input, LANES*CC_W: lane i at bits [i*CC_W +: CC_W].
REQ-013 SHALL have port in_last, input, 1: beat closes the current batch.
REQ-014 SHALL have port in_ecc, input, 1: upstream error for this beat.
REQ-015 SHALL have port res_valid, output, 1: result available.
REQ-016 SHALL have port res_ready, input, 1: result consumed when res_valid&&res_ready.
REQ-017 SHALL have port res_sum, output, SUM_W: sum of 2^count over the batch.
REQ-018 SHALL have port res_num, output, NUM_W: number of valid lane counts in the batch.
REQ-019 SHALL have port res_err, output, 1: batch saw an error.

Function
REQ-020 SHALL decode each valid lane to 2^count; a lane with count>MAX_COUNT contributes 0, is still counted in res_num, and flags an error.
REQ-021 SHALL register the decoded lane sum, popcount and error in stage 1, then add them into the batch accumulators in stage 2.
REQ-022 SHALL accumulate the batch error as the OR of in_ecc and the over-range flags of accepted beats.
REQ-023 SHALL, on the accepted in_last beat, write {acc+beat contribution} to the result buffer in stage 2; res_valid rises 2 cycles after acceptance when the buffer was empty.
REQ-024 SHALL start the next batch from zero in the cycle after the last beat's stage 2, so back-to-back batches lose no beats.
REQ-025 SHALL treat an accepted in_last beat with in_lane_valid=0 as valid, producing sum 0, num 0, err=in_ecc.
REQ-026 SHALL ignore in_lane_valid, in_count, in_last and in_ecc when the beat is not accepted.
REQ-027 SHALL implement the result buffer as a FIFO of RES_DEPTH entries; res_* show the head entry and remain stable while res_valid&&!res_ready.
REQ-028 SHALL drive in_ready low when buffer occupancy plus last beats in flight in stages 1-2 is >= RES_DEPTH.
REQ-029 SHALL allow a buffer push and pop in the same cycle with occupancy unchanged.
REQ-030 SHALL never drop or duplicate a result.

Reset
REQ-031 SHALL, while rst is high, clear the stages, accumulators and buffer, and drive in_ready=0, res_valid=0, res_sum=0, res_num=0 and res_err=0.
REQ-032 SHALL assert in_ready in the first cycle after rst deasserts.
REQ-033 SHALL discard a partial batch and in-flight results when rst asserts mid-operation.

Configuration
REQ-034 SHALL, with macro AGG_SATURATE_EN defined, saturate the accumulated sum and num at all-ones and force err for that batch on saturation.
REQ-035 SHALL, without AGG_SATURATE_EN, let the sum and num wrap modulo 2^SUM_W and 2^NUM_W with no error.

Verification
REQ-036 SHALL cover a single beat with mask 4'b1111, counts {0,1,2,35}, in_last=1 -> 2 cycles later sum=2^35+7, num=4, err=0.
REQ-037 SHALL cover 3 beats with mask 4'b0011, counts 5, last on beat 3 -> sum=192, num=6; a following beat with count 3 on lane 0 and last -> sum=8, num=1.
REQ-038 SHALL cover a lane count of 36 in a batch -> err=1, that lane adds 0 to sum and 1 to num; the next batch -> err=0.
REQ-039 SHALL cover res_ready=0 with 3 single-beat batches, RES_DEPTH=2 -> in_ready falls after 2 batches in flight, and releasing res_ready delivers 3 results in order.
REQ-040 SHALL cover rst pulsed mid-batch -> no result emitted, and the next batch with count 1 on lane 0 -> sum=2, num=1.
REQ-041 SHALL cover NUM_W=2 with 5 counts of 0 in one batch -> with AGG_SATURATE_EN num=3, err=1; without it num=1, err=0.
